// File: rtl/conversor_binario_bcd.sv
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble) algorithm.
// One operand bit per clock; the result and overflow flag are registered on completion.
module conversor_binario_bcd #(
    parameter int unsigned NUM_BITS   = 16,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [NUM_BITS-1:0]     i_binary,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_overflow
);

    localparam int unsigned BcdW = 4 * NUM_DIGITS;
    localparam int unsigned CntW = $clog2(NUM_BITS);
    localparam logic [CntW-1:0] LastIter = CntW'(NUM_BITS - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              r_state;
    logic [NUM_BITS-1:0] r_operand;
    logic [BcdW-1:0]     r_scratch;
    logic                r_ovf;
    logic [CntW-1:0]     r_count;

    logic [BcdW-1:0]     w_adjusted;
    logic [BcdW-1:0]     w_shifted;
    logic                w_carry;

    always_comb begin
        w_adjusted = r_scratch;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adjusted[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is lost from the result and flags overflow.
    assign w_carry   = w_adjusted[BcdW-1];
    assign w_shifted = {w_adjusted[BcdW-2:0], r_operand[NUM_BITS-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_operand  <= '0;
            r_scratch  <= '0;
            r_ovf      <= 1'b0;
            r_count    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_bcd      <= '0;
            o_overflow <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_operand <= i_binary;
                        r_scratch <= '0;
                        r_ovf     <= 1'b0;
                        r_count   <= '0;
                        o_busy    <= 1'b1;
                        r_state   <= StShift;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StShift: begin
                    r_scratch <= w_shifted;
                    r_operand <= {r_operand[NUM_BITS-2:0], 1'b0};
                    r_ovf     <= r_ovf | w_carry;
                    r_count   <= r_count + 1'b1;
                    if (r_count == LastIter) begin
                        o_bcd      <= w_shifted;
                        o_overflow <= r_ovf | w_carry;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        r_state    <= StDone;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Directed bench for conversor_binario_bcd: vector table plus corner-case sequences.
module tb_conversor_binario_bcd;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_binary;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_bcd;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;

    conversor_binario_bcd #(
        .NUM_BITS   (16),
        .NUM_DIGITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_binary   (i_binary),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bcd      (o_bcd),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the FSM idle; i_binary is scrambled during SHIFT.
    task automatic convert(input logic [15:0] bin, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input string name);
        int n;
        int busy_n;
        bit got;
        i_binary = bin;
        i_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        busy_n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (o_busy) busy_n++;
            i_binary = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            n++;
            if (o_done) got = 1'b1;
        end
        chk({name, " done seen"}, 32'(got), 32'd1);
        chk({name, " latency"}, 32'(n), 32'd16);
        chk({name, " busy cycles"}, 32'(busy_n), 32'd16);
        chk({name, " busy at done"}, 32'(o_busy), 32'd0);
        chk({name, " bcd"}, 32'(o_bcd), 32'(exp_bcd));
        chk({name, " ovf"}, 32'(o_overflow), 32'(exp_ovf));
        @(posedge clk);
        @(negedge clk);
        chk({name, " done single"}, 32'(o_done), 32'd0);
        chk({name, " bcd hold"}, 32'(o_bcd), 32'(exp_bcd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        int   n;
        int   k;
        int   prev;
        int   dones;
        logic [15:0] seen;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{16'h04D2, 16'h1234, 1'b0};
        vecs[2] = '{16'h270F, 16'h9999, 1'b0};
        vecs[3] = '{16'h2710, 16'h0000, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h5535, 1'b1};
        vecs[5] = '{16'h0457, 16'h1111, 1'b0};
        vecs[6] = '{16'h002A, 16'h0042, 1'b0};
        vecs[7] = '{16'h0009, 16'h0009, 1'b0};
        vecs[8] = '{16'h000A, 16'h0010, 1'b0};
        vecs[9] = '{16'h4E20, 16'h0000, 1'b1};

        rst      = 1'b0;
        i_start  = 1'b0;
        i_binary = 16'h0000;
        #12;
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset done", 32'(o_done), 32'd0);
        chk("reset bcd", 32'(o_bcd), 32'd0);
        chk("reset ovf", 32'(o_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        // Start during busy is dropped, not queued.
        i_binary = 16'h04D2;
        i_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        dones = 0;
        seen  = 16'h0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                i_start  = 1'b1;
                i_binary = 16'h0007;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (o_done) begin
                dones++;
                seen = o_bcd;
            end
        end
        chk("ignore done count", 32'(dones), 32'd1);
        chk("ignore bcd", 32'(seen), 32'h1234);

        // Held start: back-to-back results every 17 cycles.
        i_binary = 16'h04D2;
        i_start  = 1'b1;
        n = 0;
        k = 0;
        prev = 0;
        while (k < 3 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (o_done) begin
                chk($sformatf("held bcd%0d", k), 32'(o_bcd), 32'h1234);
                if (k > 0) chk($sformatf("held period%0d", k), 32'(n - prev), 32'd17);
                prev = n;
                k++;
            end
        end
        chk("held done count", 32'(k), 32'd3);
        i_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("held back to idle", 32'(o_busy), 32'd0);

        // Reset in the middle of a conversion aborts it.
        i_binary = 16'h270F;
        i_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort busy before", 32'(o_busy), 32'd1);
        rst     = 1'b0;
        i_start = 1'b1;
        #1;
        chk("abort busy", 32'(o_busy), 32'd0);
        chk("abort bcd", 32'(o_bcd), 32'd0);
        chk("abort ovf", 32'(o_overflow), 32'd0);
        chk("abort done", 32'(o_done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("no accept in reset", 32'(o_busy), 32'd0);
        i_start = 1'b0;
        rst     = 1'b1;
        dones   = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_done) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        convert(16'h002A, 16'h0042, 1'b0, "after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conversor_binario_bcd.md
CONVERSOR_BINARIO_BCD -- requirements
Module: conversor_binario_bcd

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 16, giving the binary operand width (legal range 4 to 32).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD output digits (legal range 1 to 10).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_start, input, 1 bit: conversion request, sampled on the rising edge of clk.
REQ-006 The block SHALL have port i_binary, input, NUM_BITS bits: unsigned operand, captured only on an accepting edge.
REQ-007 The block SHALL have port o_busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port o_done, output, 1 bit: one-cycle pulse marking a new result.
REQ-009 The block SHALL have port o_bcd, output, 4*NUM_DIGITS bits: packed BCD result, digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port o_overflow, output, 1 bit: the last result exceeded 10^NUM_DIGITS - 1.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 The block SHALL accept i_start only when o_busy=0 (state IDLE or DONE); on the accepting edge it loads i_binary into an operand register, clears the scratch BCD register and overflow flag, zeroes the iteration counter and enters SHIFT.
REQ-013 Each edge in SHIFT SHALL perform one shift-add-3 iteration: add 3 to every scratch digit >= 5, then shift {scratch, operand} left by one bit, with the operand MSB entering digit 0.
REQ-014 Any 1 shifted out of the top scratch digit SHALL set the sticky internal overflow flag.
REQ-015 On the edge performing iteration NUM_BITS-1, the block SHALL copy the scratch result to o_bcd and the flag to o_overflow, and enter DONE.
REQ-016 o_busy SHALL be 1 exactly in SHIFT; o_done SHALL be 1 exactly in DONE (registered, single cycle).
REQ-017 Latency SHALL be NUM_BITS cycles: accept on edge E0 -> o_done high during the cycle following edge E(NUM_BITS).
REQ-018 From DONE, an asserted i_start SHALL start a new conversion (back-to-back, one result per NUM_BITS+1 cycles); otherwise the FSM SHALL return to IDLE.
REQ-019 i_start while o_busy=1 SHALL be ignored with no queuing; i_binary changes after acceptance SHALL NOT affect the result.
REQ-020 On overflow, o_bcd SHALL hold the value mod 10^NUM_DIGITS (low digits) and o_overflow=1.
REQ-021 o_bcd and o_overflow SHALL change only on the edge that enters DONE and SHALL hold between results.

Reset
REQ-022 rst=0 SHALL immediately force state IDLE, o_busy=0, o_done=0, o_bcd=0, o_overflow=0, and clear all internal registers, independent of clk.
REQ-023 A reset during SHIFT SHALL abort the conversion with no o_done pulse; the first accepted start after release SHALL convert normally.
REQ-024 No i_start SHALL be accepted on a rising edge while rst=0.

Verification
REQ-025 Reset, then i_binary=0x0000 with one-cycle start -> o_busy high for 16 cycles, o_done pulses once 16 cycles after acceptance, o_bcd=0x0000, o_overflow=0.
REQ-026 i_binary=1234 (0x04D2) -> o_bcd=0x1234, o_overflow=0; i_binary=9999 (0x270F) -> o_bcd=0x9999, o_overflow=0.
REQ-027 i_binary=10000 (0x2710) -> o_bcd=0x0000, o_overflow=1; i_binary=65535 (0xFFFF) -> o_bcd=0x5535, o_overflow=1.
REQ-028 Start 0x04D2, then pulse start with 0x0007 at cycle 5 -> second start ignored, single done with 0x1234; i_start held high continuously -> done every 17 cycles, results correct.
REQ-029 Start 0x270F, assert rst at cycle 8 -> outputs 0 immediately and no done pulse; after release, start 0x002A -> o_bcd=0x0042.
REQ-030 Change i_binary every cycle during SHIFT after start with 0x0457 -> o_bcd=0x1111, o_overflow=0.
